// File: rtl/duty_sequencer.sv
// Triangle duty-cycle sequencer: ramps 0->255, holds, ramps down, holds, and repeats.
// A manual override drives the duty output from sw and freezes the sequence.
module duty_sequencer #(
  parameter int unsigned STEP_DIV   = 390_625,
  parameter int unsigned HOLD_STEPS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       manual,
  input  logic [7:0] sw,
  output logic [7:0] duty,
  output logic [1:0] phase,
  output logic       step_strobe,
  output logic       cycle_done,
  output logic [7:0] cycles
);

  localparam int unsigned PW = 27;
  localparam int unsigned RW = 8;
  localparam int unsigned HW = 16;

  localparam logic [PW-1:0] PRE_LAST  = PW'(STEP_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [RW-1:0] RAMP_MAX  = '1;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    HOLD_HI = 2'd1,
    DOWN    = 2'd2,
    HOLD_LO = 2'd3
  } phase_t;

  phase_t          state, state_nxt;
  logic [PW-1:0]   pre;
  logic [RW-1:0]   ramp, ramp_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [RW-1:0]   cycles_nxt;
  logic            done_nxt;
  logic [RW-1:0]   duty_nxt;
  logic            advance;
  logic            step;

  // Manual mode freezes everything exactly like en=0
  assign advance = en & ~manual;
  assign step    = advance & (pre == PRE_LAST);
  assign phase   = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= UP;
    else     state <= state_nxt;
  end

  // Next-state and sequence datapath
  always_comb begin
    state_nxt  = state;
    ramp_nxt   = ramp;
    hold_nxt   = hold_cnt;
    cycles_nxt = cycles;
    done_nxt   = 1'b0;
    if (step) begin
      case (state)
        UP: begin
          if (ramp == RAMP_MAX) begin
            state_nxt = HOLD_HI;
            hold_nxt  = '0;
          end else begin
            ramp_nxt = RW'(ramp + RW'(1));
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) state_nxt = DOWN;
          else                       hold_nxt  = HW'(hold_cnt + HW'(1));
        end
        DOWN: begin
          if (ramp == '0) begin
            state_nxt = HOLD_LO;
            hold_nxt  = '0;
          end else begin
            ramp_nxt = RW'(ramp - RW'(1));
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt  = UP;
            cycles_nxt = RW'(cycles + RW'(1));
            done_nxt   = 1'b1;
          end else begin
            hold_nxt = HW'(hold_cnt + HW'(1));
          end
        end
        default: state_nxt = UP;
      endcase
    end
  end

  // Output selection: sw in manual mode, otherwise the post-update ramp
  always_comb begin
    duty_nxt = ramp_nxt;
    if (manual) duty_nxt = sw;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pre         <= '0;
      ramp        <= '0;
      hold_cnt    <= '0;
      cycles      <= '0;
      duty        <= '0;
      step_strobe <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      if (advance) pre <= step ? '0 : PW'(pre + PW'(1));
      ramp        <= ramp_nxt;
      hold_cnt    <= hold_nxt;
      cycles      <= cycles_nxt;
      duty        <= duty_nxt;
      step_strobe <= step;
      cycle_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_duty_sequencer.sv
// Directed bench for duty_sequencer: STEP_DIV=4/HOLD_STEPS=2 main instance plus a STEP_DIV=1 instance.
module tb_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       manual = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] duty;
  logic [1:0] phase;
  logic       step_strobe;
  logic       cycle_done;
  logic [7:0] cycles;

  logic       rst1 = 1'b1;
  logic       en1 = 1'b0;
  logic [7:0] duty1;
  logic [1:0] phase1;
  logic       strobe1;
  logic       done1;
  logic [7:0] cycles1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  duty_sequencer #(.STEP_DIV(4), .HOLD_STEPS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .manual(manual), .sw(sw),
    .duty(duty), .phase(phase), .step_strobe(step_strobe),
    .cycle_done(cycle_done), .cycles(cycles)
  );

  duty_sequencer #(.STEP_DIV(1), .HOLD_STEPS(2)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .manual(1'b0), .sw(8'h00),
    .duty(duty1), .phase(phase1), .step_strobe(strobe1),
    .cycle_done(done1), .cycles(cycles1)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    manual = 1'b0;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (duty !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty); end
    checks++;
    if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
    checks++;
    if (step_strobe !== 1'b0 || cycle_done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got %b%b want 00", step_strobe, cycle_done);
    end
    checks++;
    if (cycles !== 8'd0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", cycles); end
  endtask

  // Ends with 1024 enabled clocks since reset
  task automatic test_ramp_up();
    en = 1'b1;
    tick(3);
    checks++;
    if (duty !== 8'd0 || step_strobe !== 1'b0) begin
      errors++; $display("FAIL pre_first_step: duty %0d strobe %b want 0 0", duty, step_strobe);
    end
    tick(1);
    checks++;
    if (duty !== 8'd1 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL first_step: duty %0d strobe %b want 1 1", duty, step_strobe);
    end
    tick(1);
    checks++;
    if (step_strobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b want 0", step_strobe); end
    tick(1015);
    checks++;
    if (duty !== 8'd255 || phase !== 2'd0) begin
      errors++; $display("FAIL ramp_top: duty %0d phase %0d want 255 0", duty, phase);
    end
    tick(4);
    checks++;
    if (phase !== 2'd1 || duty !== 8'd255 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL enter_hold_hi: phase %0d duty %0d strobe %b want 1 255 1", phase, duty, step_strobe);
    end
  endtask

  task automatic test_full_cycle();
    int done_cnt = 0;
    int done_at = 0;
    int lo_seen = 0;
    int lo_bad = 0;
    for (int k = 1025; k <= 2064; k++) begin
      tick(1);
      if (cycle_done === 1'b1) begin done_cnt++; done_at = k; end
      if (phase === 2'd3) begin
        lo_seen++;
        if (duty !== 8'd0) lo_bad++;
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != 2064) begin
      errors++; $display("FAIL cycle_done: count %0d at %0d want 1 at 2064", done_cnt, done_at);
    end
    checks++;
    if (cycles !== 8'd1 || phase !== 2'd0) begin
      errors++; $display("FAIL cycle_count: cycles %0d phase %0d want 1 0", cycles, phase);
    end
    checks++;
    if (lo_seen != 8 || lo_bad != 0) begin
      errors++; $display("FAIL hold_lo: seen %0d nonzero %0d want 8 0", lo_seen, lo_bad);
    end
    tick(1);
    checks++;
    if (cycle_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", cycle_done); end
  endtask

  // Entered with prescaler at 1 and ramp 0 in UP
  task automatic test_freeze();
    tick(41);
    checks++;
    if (duty !== 8'd10 || phase !== 2'd0) begin
      errors++; $display("FAIL pre_freeze: duty %0d phase %0d want 10 0", duty, phase);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (duty !== 8'd10 || phase !== 2'd0 || step_strobe !== 1'b0) begin
        errors++; $display("FAIL freeze_hold: duty %0d phase %0d strobe %b want 10 0 0", duty, phase, step_strobe);
      end
    end
    en = 1'b1;
    tick(1);
    checks++;
    if (duty !== 8'd10 || step_strobe !== 1'b0) begin
      errors++; $display("FAIL resume_early: duty %0d strobe %b want 10 0", duty, step_strobe);
    end
    tick(1);
    checks++;
    if (duty !== 8'd11 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL resume_step: duty %0d strobe %b want 11 1", duty, step_strobe);
    end
  endtask

  task automatic test_manual();
    int strobes = 0;
    do_reset();
    en = 1'b1;
    tick(1652);
    checks++;
    if (duty !== 8'd100 || phase !== 2'd2) begin
      errors++; $display("FAIL pre_manual: duty %0d phase %0d want 100 2", duty, phase);
    end
    manual = 1'b1;
    sw = 8'hA5;
    tick(1);
    checks++;
    if (duty !== 8'hA5) begin errors++; $display("FAIL manual_duty: got %h want a5", duty); end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (step_strobe !== 1'b0 || cycle_done !== 1'b0) strobes++;
    end
    checks++;
    if (strobes != 0 || duty !== 8'hA5 || phase !== 2'd2) begin
      errors++; $display("FAIL manual_hold: strobes %0d duty %h phase %0d want 0 a5 2", strobes, duty, phase);
    end
    manual = 1'b0;
    tick(1);
    checks++;
    if (duty !== 8'd100 || step_strobe !== 1'b0) begin
      errors++; $display("FAIL manual_release: duty %0d strobe %b want 100 0", duty, step_strobe);
    end
    tick(3);
    checks++;
    if (duty !== 8'd99 || step_strobe !== 1'b1 || phase !== 2'd2) begin
      errors++; $display("FAIL descent_resume: duty %0d strobe %b phase %0d want 99 1 2", duty, step_strobe, phase);
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    en = 1'b1;
    tick(1027);
    checks++;
    if (phase !== 2'd1) begin errors++; $display("FAIL pre_rst_phase: got %0d want 1", phase); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (duty !== 8'd0 || phase !== 2'd0 || cycles !== 8'd0 || step_strobe !== 1'b0 || cycle_done !== 1'b0) begin
      errors++; $display("FAIL rst_priority: duty %0d phase %0d cycles %0d strobe %b done %b want all 0",
                         duty, phase, cycles, step_strobe, cycle_done);
    end
    tick(3);
    checks++;
    if (duty !== 8'd0 || step_strobe !== 1'b0) begin
      errors++; $display("FAIL rst_restart_early: duty %0d strobe %b want 0 0", duty, step_strobe);
    end
    tick(1);
    checks++;
    if (duty !== 8'd1 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL rst_restart_step: duty %0d strobe %b want 1 1", duty, step_strobe);
    end
  endtask

  task automatic test_step_div_one();
    int bad = 0;
    rst1 = 1'b1;
    tick(1);
    rst1 = 1'b0;
    en1 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick(1);
      if (duty1 !== 8'(i) || strobe1 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fast_ramp: %0d bad cycles want 0", bad); end
    checks++;
    if (duty1 !== 8'd255 || phase1 !== 2'd0) begin
      errors++; $display("FAIL fast_top: duty %0d phase %0d want 255 0", duty1, phase1);
    end
    tick(1);
    checks++;
    if (phase1 !== 2'd1 || strobe1 !== 1'b1) begin
      errors++; $display("FAIL fast_hold_hi: phase %0d strobe %b want 1 1", phase1, strobe1);
    end
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_full_cycle();
    test_freeze();
    test_manual();
    test_reset_priority();
    test_step_div_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
